// File: rtl/mult_sched_pkg.sv
// ---------------------------------------------------------------------------
// mult_sched_pkg
// Shared types and defaults for the two-requester multiplier scheduler.
//   state_e         : scheduler FSM states
//   req_id_t        : requester index (0 or 1)
//   DEFAULT_DATA_W  : operand width; products are twice this width
//   DEFAULT_TIMEOUT : BUSY-cycle budget before the core is aborted
//   CORE_LATENCY    : nominal start-to-done latency of the shift-add core
//   onehot_to_id()  : converts a 2-bit one-hot grant into a requester index
// ---------------------------------------------------------------------------
package mult_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  typedef logic req_id_t;

  localparam int DEFAULT_DATA_W  = 32;
  localparam int DEFAULT_TIMEOUT = 40;
  localparam int CORE_LATENCY    = 33;

  // Only meaningful for a one-hot or zero input; bit 1 alone selects id 1.
  function automatic req_id_t onehot_to_id(input logic [1:0] oh);
    return req_id_t'(oh[1] & ~oh[0]);
  endfunction

endpackage

// File: rtl/mult_sched_if.sv
// ---------------------------------------------------------------------------
// mult_sched_if
// Bundles the requester handshakes and the multiplier-core control/data
// signals that the scheduler talks to.
//   slave  : scheduler view (drives req_ready, rsp_*, core_start/abort/a/b)
//   master : environment view (requesters plus the multiplier core)
// Requester i operands live in req_a/req_b bits [i*DATA_W +: DATA_W].
// ---------------------------------------------------------------------------
interface mult_sched_if #(
  parameter int DATA_W = mult_sched_pkg::DEFAULT_DATA_W
);

  // Requester side
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [2*DATA_W-1:0] req_a;
  logic [2*DATA_W-1:0] req_b;
  logic [1:0]          rsp_valid;
  logic [1:0]          rsp_ready;
  logic [2*DATA_W-1:0] rsp_result;
  logic                rsp_err;

  // Multiplier core side
  logic                core_start;
  logic                core_abort;
  logic [DATA_W-1:0]   core_a;
  logic [DATA_W-1:0]   core_b;
  logic                core_done;
  logic [2*DATA_W-1:0] core_result;

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, core_done, core_result,
    output req_ready, rsp_valid, rsp_result, rsp_err,
           core_start, core_abort, core_a, core_b
  );

  modport master (
    output req_valid, req_a, req_b, rsp_ready, core_done, core_result,
    input  req_ready, rsp_valid, rsp_result, rsp_err,
           core_start, core_abort, core_a, core_b
  );

endinterface

// File: rtl/mult_sched_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Purely combinational 2-way round-robin arbiter.
//   req_valid [1:0] in  : per-requester request
//   ptr             in  : favoured requester when both request
//   grant     [1:0] out : one-hot grant (zero when nobody requests)
// ---------------------------------------------------------------------------
module rr_arb2
  import mult_sched_pkg::*;
(
  input  logic [1:0] req_valid,
  input  req_id_t    ptr,
  output logic [1:0] grant
);

  // A requester wins if it is favoured, or if the other one is not asking.
  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    assign grant[gi] = req_valid[gi] & ((ptr == req_id_t'(gi)) | ~req_valid[1-gi]);
  end

endmodule

// File: rtl/mult_sched.sv
// ---------------------------------------------------------------------------
// mult_sched
// Time-shares one sequential multiplier core between two requesters.
// A round-robin winner's operands are latched, the core is launched with a
// one-cycle start pulse, and a watchdog aborts the core if it overruns.
// The product (or a zero result with rsp_err set) is held on the winner's
// response channel until accepted.
//   clk   in : rising-edge clock
//   reset in : asynchronous, active-low; clears all state
//   bus       : mult_sched_if.slave (requester handshakes + core control)
// ---------------------------------------------------------------------------
module mult_sched
  import mult_sched_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  mult_sched_if.slave bus
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e              state_q, state_d;
  req_id_t             ptr_q, ptr_d;
  req_id_t             owner_q, owner_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [1:0]          grant;
  logic [1:0]          req_ready_c;
  logic [1:0]          rsp_valid_c;
  logic                start_c;
  logic                abort_c;

  // Unpack the per-requester operand lanes.
  logic [DATA_W-1:0]   lane_a [2];
  logic [DATA_W-1:0]   lane_b [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    assign lane_a[gi] = bus.req_a[gi*DATA_W +: DATA_W];
    assign lane_b[gi] = bus.req_b[gi*DATA_W +: DATA_W];
  end

  rr_arb2 u_arb (
    .req_valid (bus.req_valid),
    .ptr       (ptr_q),
    .grant     (grant)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    a_d         = a_q;
    b_d         = b_q;
    result_d    = result_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    req_ready_c = 2'b00;
    rsp_valid_c = 2'b00;
    start_c     = 1'b0;
    abort_c     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        req_ready_c = grant;
        if (grant != 2'b00) begin
          owner_d = onehot_to_id(grant);
          a_d     = lane_a[onehot_to_id(grant)];
          b_d     = lane_b[onehot_to_id(grant)];
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        start_c = 1'b1;
        cnt_d   = '0;
        state_d = ST_BUSY;
      end

      ST_BUSY: begin
        // Completion takes precedence over a watchdog expiry in the same cycle.
        if (bus.core_done) begin
          result_d = bus.core_result;
          err_d    = 1'b0;
          state_d  = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          abort_c  = 1'b1;
          result_d = '0;
          err_d    = 1'b1;
          state_d  = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_RESP: begin
        rsp_valid_c[owner_q] = 1'b1;
        if (bus.rsp_ready[owner_q]) begin
          ptr_d   = ~owner_q;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // req_ready is the only output that follows inputs combinationally, so it
  // is masked while reset is held to keep every output at its reset value.
  assign bus.req_ready  = req_ready_c & {2{reset}};
  assign bus.rsp_valid  = rsp_valid_c;
  assign bus.rsp_result = result_q;
  assign bus.rsp_err    = err_q;
  assign bus.core_start = start_c;
  assign bus.core_abort = abort_c;
  assign bus.core_a     = a_q;
  assign bus.core_b     = b_q;

endmodule

// File: tb/tb_mult_sched.sv
// ---------------------------------------------------------------------------
// tb_mult_sched
// Directed bench for mult_sched with a behavioural multiplier core whose
// latency is adjustable and which can be told never to finish. Expected
// responses are queued at grant time and compared when the response appears.
// ---------------------------------------------------------------------------
module tb_mult_sched;
  import mult_sched_pkg::*;

  localparam int DW = 32;

  typedef struct {
    logic        owner;
    logic [63:0] res;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   abort_cnt = 0;

  exp_t sb[$];

  // Core model controls
  int   core_lat = CORE_LATENCY;
  bit   core_hang = 1'b0;
  bit   stray_done = 1'b0;
  logic busy_m;
  int   rem_m;
  logic [63:0] pend_m;

  mult_sched_if #(.DATA_W(DW)) bus ();

  mult_sched #(.DATA_W(DW), .TIMEOUT(40)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.core_abort) abort_cnt <= abort_cnt + 1;
  end

  // Behavioural core: done arrives core_lat cycles after the start cycle.
  // core_result carries junk except in the done cycle.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_m          <= 1'b0;
      rem_m           <= 0;
      pend_m          <= '0;
      bus.core_done   <= 1'b0;
      bus.core_result <= 64'hDEAD_BEEF_DEAD_BEEF;
    end else begin
      bus.core_done   <= stray_done;
      bus.core_result <= 64'hDEAD_BEEF_DEAD_BEEF;
      if (bus.core_abort) begin
        busy_m <= 1'b0;
      end else if (bus.core_start) begin
        busy_m <= 1'b1;
        rem_m  <= core_lat - 1;
        pend_m <= {32'b0, bus.core_a} * {32'b0, bus.core_b};
      end else if (busy_m && !core_hang) begin
        if (rem_m == 1) begin
          bus.core_done   <= 1'b1;
          bus.core_result <= pend_m;
          busy_m          <= 1'b0;
        end else begin
          rem_m <= rem_m - 1;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b);
    return {32'b0, a} * {32'b0, b};
  endfunction

  task automatic drive(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] b0,
                       input logic [31:0] a1, input logic [31:0] b1);
    bus.req_valid = v;
    bus.req_a     = {a1, a0};
    bus.req_b     = {b1, b0};
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"},  {62'b0, bus.req_ready}, 64'd0);
    check({tag, "_rsp_valid"},  {62'b0, bus.rsp_valid}, 64'd0);
    check({tag, "_rsp_result"}, bus.rsp_result, 64'd0);
    check({tag, "_rsp_err"},    {63'b0, bus.rsp_err}, 64'd0);
    check({tag, "_core_start"}, {63'b0, bus.core_start}, 64'd0);
    check({tag, "_core_abort"}, {63'b0, bus.core_abort}, 64'd0);
    check({tag, "_core_a"},     {32'b0, bus.core_a}, 64'd0);
    check({tag, "_core_b"},     {32'b0, bus.core_b}, 64'd0);
  endtask

  // Called at a negedge with requests driven. Returns at the negedge of T+2.
  task automatic await_grant(input string tag, input logic [1:0] exp_grant,
                             input logic exp_err, output int t);
    bit          got;
    logic        idx;
    logic [31:0] a, b;
    exp_t        e;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      #1;
      if ((bus.req_ready & bus.req_valid) != 2'b00) got = 1'b1;
      else @(negedge clk);
    end
    t = cyc;
    check({tag, "_grant"}, {62'b0, bus.req_ready}, {62'b0, exp_grant});
    if (got) begin
      idx   = bus.req_ready[1];
      a     = idx ? bus.req_a[63:32] : bus.req_a[31:0];
      b     = idx ? bus.req_b[63:32] : bus.req_b[31:0];
      e.owner = idx;
      e.res   = exp_err ? 64'd0 : mul64(a, b);
      e.err   = exp_err;
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      bus.req_valid[idx] = 1'b0;
      check({tag, "_start"},  {63'b0, bus.core_start}, 64'd1);
      check({tag, "_core_a"}, {32'b0, bus.core_a}, {32'b0, a});
      check({tag, "_core_b"}, {32'b0, bus.core_b}, {32'b0, b});
      @(negedge clk);
      check({tag, "_start_off"}, {63'b0, bus.core_start}, 64'd0);
    end
    $display("grant  %s cycle=%0d grant=%b", tag, t, bus.req_ready);
  endtask

  // Waits for a response, compares it with the scoreboard, optionally holds
  // rsp_ready low for 'hold' cycles, then completes the handshake.
  task automatic await_rsp(input string tag, input int hold, output int t);
    bit          got;
    exp_t        e;
    logic [1:0]  exp_v;
    logic [1:0]  v0;
    logic [63:0] r0;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      if (bus.rsp_valid != 2'b00) got = 1'b1;
      else @(negedge clk);
    end
    t = cyc;
    if (sb.size() == 0) begin
      check({tag, "_unexpected"}, {62'b0, bus.rsp_valid}, 64'd0);
      return;
    end
    e     = sb.pop_front();
    exp_v = e.owner ? 2'b10 : 2'b01;
    check({tag, "_rsp_valid"},  {62'b0, bus.rsp_valid}, {62'b0, exp_v});
    check({tag, "_rsp_result"}, bus.rsp_result, e.res);
    check({tag, "_rsp_err"},    {63'b0, bus.rsp_err}, {63'b0, e.err});
    check({tag, "_no_ready"},   {62'b0, bus.req_ready}, 64'd0);
    $display("resp   %s cycle=%0d valid=%b result=%0h err=%b", tag, t,
             bus.rsp_valid, bus.rsp_result, bus.rsp_err);
    if (got) begin
      v0 = bus.rsp_valid;
      r0 = bus.rsp_result;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check({tag, "_hold_valid"},  {62'b0, bus.rsp_valid}, {62'b0, v0});
        check({tag, "_hold_result"}, bus.rsp_result, r0);
        check({tag, "_hold_ready"},  {62'b0, bus.req_ready}, 64'd0);
      end
      bus.rsp_ready = exp_v;
      @(posedge clk);
      @(negedge clk);
      check({tag, "_rsp_drop"}, {62'b0, bus.rsp_valid}, 64'd0);
      bus.rsp_ready = 2'b00;
    end
  endtask

  initial begin
    int t_g, t_r, ab0;

    // Reset with both requesters asserting: no grant may leak out.
    bus.rsp_ready = 2'b00;
    drive(2'b11, 32'd1, 32'd1, 32'd1, 32'd1);
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    drive(2'b00, 32'd0, 32'd0, 32'd0, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Single requester 0: 3*5, full latency check.
    core_lat = 33;
    drive(2'b01, 32'd3, 32'd5, 32'd0, 32'd0);
    await_grant("t1", 2'b01, 1'b0, t_g);
    bus.req_a[31:0] = 32'hABCD_0123;
    @(negedge clk);
    check("t1_operand_held", {32'b0, bus.core_a}, 64'd3);
    await_rsp("t1", 0, t_r);
    check("t1_latency", 64'(t_r - t_g), 64'd35);

    // ptr now favours requester 1, but requester 0 alone still wins.
    drive(2'b01, 32'd7, 32'd9, 32'd0, 32'd0);
    await_grant("t1b", 2'b01, 1'b0, t_g);
    await_rsp("t1b", 0, t_r);

    // Stray core_done in IDLE is ignored.
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    @(negedge clk);
    check("stray_rsp_valid", {62'b0, bus.rsp_valid}, 64'd0);
    check("stray_start", {63'b0, bus.core_start}, 64'd0);

    // Contention from reset: 0 then 1, then 0 and 1 again.
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    drive(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'd6);
    await_grant("t2a", 2'b01, 1'b0, t_g);
    await_rsp("t2a", 0, t_r);
    await_grant("t2b", 2'b10, 1'b0, t_g);
    await_rsp("t2b", 0, t_r);
    drive(2'b11, 32'd100, 32'd200, 32'h1234_5678, 32'h9ABC_DEF0);
    await_grant("t2c", 2'b01, 1'b0, t_g);
    await_rsp("t2c", 0, t_r);
    await_grant("t2d", 2'b10, 1'b0, t_g);
    await_rsp("t2d", 0, t_r);

    // Watchdog: core never completes.
    core_hang = 1'b1;
    ab0 = abort_cnt;
    drive(2'b10, 32'd0, 32'd0, 32'd2, 32'd2);
    await_grant("t3", 2'b10, 1'b1, t_g);
    await_rsp("t3", 0, t_r);
    check("t3_latency", 64'(t_r - t_g), 64'd42);
    check("t3_abort_count", 64'(abort_cnt - ab0), 64'd1);
    core_hang = 1'b0;

    // Response back-pressure for 10 cycles while requester 1 waits.
    core_lat = 33;
    drive(2'b01, 32'd11, 32'd13, 32'd5, 32'd5);
    await_grant("t4", 2'b01, 1'b0, t_g);
    bus.req_valid[1] = 1'b1;
    await_rsp("t4", 10, t_r);
    await_grant("t4b", 2'b10, 1'b0, t_g);
    await_rsp("t4b", 0, t_r);

    // core_done coincides with the last watchdog cycle: done wins.
    core_lat = 40;
    ab0 = abort_cnt;
    drive(2'b01, 32'd1000, 32'd1000, 32'd0, 32'd0);
    await_grant("t5", 2'b01, 1'b0, t_g);
    await_rsp("t5", 0, t_r);
    check("t5_latency", 64'(t_r - t_g), 64'd42);
    check("t5_no_abort", 64'(abort_cnt - ab0), 64'd0);

    // Reset during BUSY: everything clears at once, no abort.
    core_lat = 33;
    ab0 = abort_cnt;
    drive(2'b10, 32'd0, 32'd0, 32'd9, 32'd9);
    await_grant("t6", 2'b10, 1'b0, t_g);
    repeat (10) @(negedge clk);
    drive(2'b11, 32'd20, 32'd3, 32'd4, 32'd4);
    reset = 1'b0;
    #1;
    check_reset_outputs("t6_midreset");
    sb.delete();
    @(negedge clk);
    check("t6_no_abort", 64'(abort_cnt - ab0), 64'd0);
    reset = 1'b1;
    await_grant("t6a", 2'b01, 1'b0, t_g);
    await_rsp("t6a", 0, t_r);
    await_grant("t6b", 2'b10, 1'b0, t_g);
    await_rsp("t6b", 0, t_r);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_sched.md
# mult_sched

Two-requester scheduler that time-shares one sequential 32x32 shift-add multiplier core. It arbitrates operand requests round-robin, launches the core with a one-cycle start pulse, and watches for completion with a watchdog. It returns the 64-bit product, or an error, to the winning requester. It sits between the ALU-side requesters and the multiplier datapath/control pair.

## Interface
- `DATA_W`, 32, operand width; product is 2*DATA_W.
- `TIMEOUT`, 40, max cycles in BUSY before abort; must be greater than core latency (33).
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low (asserted at 0); clears all state.
- `req_valid`  in  2  per-requester operand valid.
- `req_ready`  out  2  one-hot accept; a request is taken when `req_valid[i] & req_ready[i]`.
- `req_a`  in  2*DATA_W  requester i operand A in bits [i*DATA_W +: DATA_W].
- `req_b`  in  2*DATA_W  requester i operand B, same packing.
- `rsp_valid`  out  2  one-hot response valid.
- `rsp_ready`  in  2  per-requester response accept.
- `rsp_result`  out  2*DATA_W  product; meaningful only while a `rsp_valid` bit is set.
- `rsp_err`  out  1  watchdog expired; `rsp_result` is 0 when set.
- `core_start`  out  1  one-cycle launch pulse to the core.
- `core_abort`  out  1  one-cycle pulse on timeout; the core returns to idle.
- `core_a`, `core_b`  out  DATA_W  operands; held stable from ISSUE through BUSY.
- `core_done`  in  1  core completion pulse.
- `core_result`  in  2*DATA_W  product; valid in the cycle `core_done` is high.

## Operation
- FSM states: IDLE -> ISSUE -> BUSY -> RESP -> IDLE.
- IDLE:
  - `req_ready` is combinational and only in IDLE. It is one-hot to the winner among `req_valid`.
  - Priority pointer `ptr` names the favoured requester; `ptr` resets to 0.
  - On accept: latch operands and owner id; go to ISSUE.
- ISSUE: assert `core_start` for exactly one cycle, clear the watchdog counter, go to BUSY.
- BUSY: the counter increments each cycle.
  - On `core_done`: capture `core_result`, set `rsp_err` to 0, go to RESP.
  - When the counter reaches `TIMEOUT-1` without `core_done`: pulse `core_abort`, set result to 0 and `rsp_err` to 1, go to RESP.
- RESP:
  - `rsp_valid[owner]` held high with result and error stable until `rsp_ready[owner]` is high.
  - Then go to IDLE and set `ptr` to the other requester (not the one just served).
- Arithmetic: the scheduler does not modify the product. It is passed through bit-exact as 2*DATA_W unsigned.

## Timing
- Reset values: `req_ready` 0, `rsp_valid` 0, `rsp_result` 0, `rsp_err` 0, `core_start` 0, `core_abort` 0, `core_a` 0, `core_b` 0. State is IDLE, `ptr` is 0.
- Latency: accept at cycle T; `core_start` at T+1; `core_done` at T+1+L; `rsp_valid` at T+2+L. The earliest next accept is the cycle after the `rsp_valid & rsp_ready` handshake.
- Simultaneous `req_valid` = 2'b11: grant goes to `ptr`. Back-to-back contention alternates 0,1,0,1.
- Single requester: it is granted regardless of `ptr`.
- `core_done` in the same cycle as the timeout: done wins, no abort, `rsp_err` is 0.
- `core_done` outside BUSY: ignored.
- `req_valid` deasserted before accept: no grant, no state change. Operands are sampled only at accept.
- `rsp_ready` already high on RESP entry: response completes in 1 cycle.
- Reset asserted mid-operation: return to IDLE immediately, all outputs at reset values, no `core_abort` pulse. The core is reset by the same `reset`.

## Structure
- Package `mult_sched_pkg`: state enum (IDLE, ISSUE, BUSY, RESP), default `TIMEOUT`, requester-id typedef.
- Sub-module `rr_arb2`: 2-way round-robin arbiter.
  - Inputs: `req_valid`, `ptr`.
  - Output: one-hot grant.
  - Purely combinational.
- The FSM, watchdog counter, and operand/result registers live in `mult_sched`.

## Test plan
- Req0 with a=3, b=5 -> `core_start` at T+1. The core (L=33) returns 15. `rsp_valid`=2'b01 with `rsp_result`=64'd15 at T+35, `rsp_err`=0.
- Both valid from reset: req0 a=32'hFFFFFFFF, b=32'hFFFFFFFF; req1 a=7, b=6.
  - Req0 is served first: 64'hFFFFFFFE00000001.
  - Req1 is served next: 42.
  - `ptr` ends at 0.
- Stubbed core never raises `core_done` -> `core_abort` pulses once after 40 BUSY cycles. `rsp_err`=1, `rsp_result`=0.
- `rsp_ready` held low 10 cycles in RESP -> `rsp_valid` and result stay stable, no new `req_ready`. Completes in the cycle `rsp_ready` rises.
- `reset` driven to 0 during BUSY -> all outputs 0 within the same cycle. A request after release is served normally with `ptr`=0.
- `core_done` coincident with counter=`TIMEOUT-1` -> normal response, `core_abort` stays 0.
